// File: rtl/pe_weight_loader_if.sv
// ============================================================================
// pe_weight_loader_if : stream input, shared weight/bias bus and load status
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface pe_weight_loader_if #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int BIAS_WIDTH   = 32,
    parameter int CORE_NUM     = 8
);
    logic                    load_start;
    logic [WEIGHT_WIDTH-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [WEIGHT_WIDTH-1:0] weight;
    logic [CORE_NUM-1:0]     weight_valid;
    logic [BIAS_WIDTH-1:0]   bias;
    logic [CORE_NUM-1:0]     bias_valid;
    logic                    busy;
    logic                    load_done;

    modport master (
        output load_start, s_data, s_valid,
        input  s_ready, weight, weight_valid, bias, bias_valid, busy, load_done
    );

    modport slave (
        input  load_start, s_data, s_valid,
        output s_ready, weight, weight_valid, bias, bias_valid, busy, load_done
    );
endinterface

`default_nettype wire

// File: rtl/pe_weight_loader.sv
// ============================================================================
// pe_weight_loader : distributes a serial weight/bias stream to CORE_NUM PE cores
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_weight_loader #(
    parameter int WEIGHT_WIDTH        = 16,
    parameter int BIAS_WIDTH          = 32,
    parameter int PE_ARRAY_TOTAL_SIZE = 9,
    parameter int CORE_NUM            = 8
) (
    input  wire logic         DSP_clk,
    input  wire logic         rst,
    pe_weight_loader_if.slave bus
);

    localparam int c_WCW = (PE_ARRAY_TOTAL_SIZE > 1) ? $clog2(PE_ARRAY_TOTAL_SIZE) : 1;
    localparam int c_CCW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam logic [c_WCW-1:0]    c_W_LAST    = c_WCW'(PE_ARRAY_TOTAL_SIZE - 1);
    localparam logic [c_CCW-1:0]    c_CORE_LAST = c_CCW'(CORE_NUM - 1);
    localparam logic [CORE_NUM-1:0] c_ONE       = CORE_NUM'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_BL = 3'd2,
        S_LOAD_BH = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_WCW-1:0]        r_w_cnt;
    logic [c_CCW-1:0]        r_core_cnt;
    logic [WEIGHT_WIDTH-1:0] r_bias_lo;
    logic [WEIGHT_WIDTH-1:0] r_weight;
    logic [CORE_NUM-1:0]     r_weight_valid;
    logic [BIAS_WIDTH-1:0]   r_bias;
    logic [CORE_NUM-1:0]     r_bias_valid;
    logic                    r_busy;
    logic                    r_load_done;
    logic                    w_s_ready;
    logic                    w_accept;

    assign w_s_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_BL) || (r_state == S_LOAD_BH);
    assign w_accept  = w_s_ready && bus.s_valid;

    always_ff @(posedge DSP_clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_w_cnt        <= '0;
            r_core_cnt     <= '0;
            r_bias_lo      <= '0;
            r_weight       <= '0;
            r_weight_valid <= '0;
            r_bias         <= '0;
            r_bias_valid   <= '0;
            r_busy         <= 1'b0;
            r_load_done    <= 1'b0;
        end else begin
            // Strobes are single-cycle; only an accepting edge re-asserts them.
            r_weight_valid <= '0;
            r_bias_valid   <= '0;
            r_load_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state    <= S_LOAD_W;
                        r_busy     <= 1'b1;
                        r_core_cnt <= '0;
                        r_w_cnt    <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (w_accept) begin
                        r_weight       <= bus.s_data;
                        r_weight_valid <= c_ONE << r_core_cnt;
                        if (r_w_cnt == c_W_LAST) begin
                            r_w_cnt <= '0;
                            r_state <= S_LOAD_BL;
                        end else begin
                            r_w_cnt <= r_w_cnt + c_WCW'(1);
                        end
                    end
                end
                S_LOAD_BL: begin
                    if (w_accept) begin
                        r_bias_lo <= bus.s_data;
                        r_state   <= S_LOAD_BH;
                    end
                end
                S_LOAD_BH: begin
                    if (w_accept) begin
                        r_bias       <= {bus.s_data, r_bias_lo};
                        r_bias_valid <= c_ONE << r_core_cnt;
                        if (r_core_cnt == c_CORE_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_core_cnt <= r_core_cnt + c_CCW'(1);
                            r_state    <= S_LOAD_W;
                        end
                    end
                end
                S_DONE: begin
                    r_load_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.weight       = r_weight;
    assign bus.weight_valid = r_weight_valid;
    assign bus.bias         = r_bias;
    assign bus.bias_valid   = r_bias_valid;
    assign bus.busy         = r_busy;
    assign bus.load_done    = r_load_done;

endmodule

`default_nettype wire
